// File: rtl/uart_apb_tx_ctrl.sv
// Byte-push front end for a cmsdk_apb_uart: configures BAUDDIV/CTRL, then polls STATE and writes DATA per byte.
// Build option UART_TX_CTRL_FIFO_EN: 2**FIFO_DEPTH_LOG2-entry FIFO; without it, a single holding register.
module uart_apb_tx_ctrl #(
  parameter logic [31:0] BAUDDIV_VAL     = 32'd16,
  parameter int          FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     PSEL,
  output logic [11:2]              PADDR,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  input  logic [31:0]              PRDATA,
  input  logic                     PREADY,
  output logic                     init_done,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam logic [9:0] A_DATA  = 10'd0;
  localparam logic [9:0] A_STATE = 10'd1;
  localparam logic [9:0] A_CTRL  = 10'd2;
  localparam logic [9:0] A_BAUD  = 10'd4;

  typedef enum logic [2:0] {
    S_INIT_BAUD,
    S_INIT_CTRL,
    S_IDLE,
    S_POLL,
    S_SEND
  } state_e;

  state_e      state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [9:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        init_done_q, init_done_d;
  logic        live_q;

  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;

  // Only the TX-buffer-full flag of STATE matters here.
  logic unused_prdata;
  assign unused_prdata = ^PRDATA[31:1];

  // tx_ready is held low until the first edge after reset release.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) live_q <= 1'b0;
    else          live_q <= 1'b1;
  end

  assign tx_ready = live_q && !fifo_full;
  assign push     = tx_valid && tx_ready;

`ifdef UART_TX_CTRL_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [7:0]                 mem_q [DEPTH];
  logic [7:0]                 mem_d [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = tx_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // count never exceeds DEPTH, so its MSB alone marks full.
  assign fifo_full  = count_q[FIFO_DEPTH_LOG2];
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = mem_q[rptr_q];
  assign fifo_count = count_q;
`else
  logic [7:0] hold_q, hold_d;
  logic       occ_q, occ_d;

  always_comb begin
    hold_d = hold_q;
    occ_d  = occ_q;
    if (pop) occ_d = 1'b0;
    if (push) begin
      hold_d = tx_data;
      occ_d  = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      hold_q <= '0;
      occ_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      occ_q  <= occ_d;
    end
  end

  assign fifo_full  = occ_q;
  assign fifo_empty = !occ_q;
  assign fifo_head  = hold_q;

  always_comb begin
    fifo_count    = '0;
    fifo_count[0] = occ_q;
  end
`endif

  // psel_q=0 launches SETUP, SETUP always moves to ACCESS, ACCESS completes on PREADY.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    init_done_d = init_done_q;
    pop         = 1'b0;
    if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (psel_q) begin
      if (PREADY) begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        case (state_q)
          S_INIT_BAUD: state_d = S_INIT_CTRL;
          S_INIT_CTRL: begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end
          S_POLL:      state_d = PRDATA[0] ? S_IDLE : S_SEND;
          S_SEND: begin
            state_d = S_IDLE;
            pop     = 1'b1;
          end
          default:     state_d = S_IDLE;
        endcase
      end
    end else begin
      case (state_q)
        S_INIT_BAUD: begin
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = A_BAUD;
          pwdata_d = BAUDDIV_VAL;
        end
        S_INIT_CTRL: begin
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = A_CTRL;
          pwdata_d = 32'h1;
        end
        S_IDLE, S_POLL: begin
          if (!fifo_empty) begin
            state_d  = S_POLL;
            psel_d   = 1'b1;
            pwrite_d = 1'b0;
            paddr_d  = A_STATE;
            pwdata_d = '0;
          end
        end
        S_SEND: begin
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = A_DATA;
          pwdata_d = {24'h0, fifo_head};
        end
        default: state_d = S_INIT_BAUD;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_INIT_BAUD;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign init_done = init_done_q;
  assign busy      = !fifo_empty || (state_q == S_POLL) || (state_q == S_SEND);

endmodule

// File: tb/tb_uart_apb_tx_ctrl.sv
// Bench for uart_apb_tx_ctrl: APB slave responder plus a transaction-level model (byte queue, init phase).
module tb_uart_apb_tx_ctrl;
`ifdef UART_TX_CTRL_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        PSEL, PENABLE, PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1;
  logic        init_done, busy;
  logic [2:0]  fifo_count;

  always #5 PCLK = ~PCLK;

  uart_apb_tx_ctrl dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .init_done(init_done), .busy(busy), .fifo_count(fifo_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: bytes accepted but not yet written, init phase, and whether a DATA write is owed.
  logic [7:0] q[$];
  logic [7:0] wlog[$];
  int  phase, reads, last_reads, pen_run, last_pen_len, wait_left;
  int  fixed_wait, force_busy;
  bit  live, expect_send, rand_busy, accepted;
  logic       prev_psel, prev_pen, prev_rdy, prev_wr;
  logic [9:0] prev_addr;
  logic [31:0] prev_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic model_reset();
    q.delete();
    phase = 0; reads = 0; pen_run = 0; wait_left = 0;
    live = 0; expect_send = 0;
    prev_psel = 0; prev_pen = 0; prev_rdy = 0; prev_wr = 0; prev_addr = '0; prev_wd = '0;
  endtask

  task automatic check_outputs();
    if (!PRESETn) begin
      chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, init_done, busy, fifo_count, tx_ready}, '0);
    end else begin
      chk("tx_ready", tx_ready, live && (q.size() < DEPTH));
      chk("fifo_count", fifo_count, q.size());
      chk("busy", busy, q.size() != 0);
      chk("init_done", init_done, phase == 2);
      if (PENABLE) chk("penable_without_psel", PSEL, 1);
      if (prev_psel && !(prev_pen && prev_rdy))
        chk("apb_hold", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {2'b11, prev_wr, prev_addr, prev_wd});
      else if (prev_psel)
        chk("apb_idle_gap", PSEL, 0);
    end
  endtask

  task automatic slave_respond();
    if (PSEL && !PENABLE) wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 2);
    PREADY = 1'b1;
    if (PSEL) begin
      PREADY = (wait_left == 0);
      if (PENABLE && wait_left > 0) wait_left--;
    end
    PRDATA = $urandom();
    if (PSEL && PENABLE && PREADY && !PWRITE && PADDR == 10'd1) begin
      if (force_busy > 0) begin
        PRDATA[0] = 1'b1;
        force_busy--;
      end else begin
        PRDATA[0] = rand_busy && ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic model_advance();
    bit rdy_m;
    logic [7:0] head;
    if (PRESETn) begin
      rdy_m = live && (q.size() < DEPTH);
      accepted = 0;
      if (PSEL && PENABLE) pen_run++;
      if (PSEL && PENABLE && PREADY) begin
        last_pen_len = pen_run;
        pen_run = 0;
        if (phase == 0) begin
          chk("baud_write", {PWRITE, PADDR, PWDATA}, {1'b1, 10'd4, 32'd16});
          phase = 1;
        end else if (phase == 1) begin
          chk("ctrl_write", {PWRITE, PADDR, PWDATA}, {1'b1, 10'd2, 32'h1});
          phase = 2;
        end else if (expect_send) begin
          head = (q.size() != 0) ? q[0] : 8'h00;
          chk("data_write", {PWRITE, PADDR, PWDATA}, {1'b1, 10'd0, 24'h0, head});
          if (q.size() != 0) void'(q.pop_front());
          wlog.push_back(PWDATA[7:0]);
          last_reads = reads;
          reads = 0;
          expect_send = 0;
        end else begin
          chk("state_read", {PWRITE, PADDR}, {1'b0, 10'd1});
          reads++;
          expect_send = !PRDATA[0];
        end
      end
      if (tx_valid && rdy_m) begin
        q.push_back(tx_data);
        accepted = 1;
      end
      live = 1;
      prev_psel = PSEL; prev_pen = PENABLE; prev_rdy = PREADY;
      prev_wr = PWRITE; prev_addr = PADDR; prev_wd = PWDATA;
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    @(negedge PCLK);
    check_outputs();
    tx_valid = v;
    tx_data  = d;
    slave_respond();
    model_advance();
  endtask

  task automatic do_reset(input int n);
    PRESETn = 1'b0;
    model_reset();
    repeat (n) cycle(1'b0, 8'h00);
    PRESETn = 1'b1;
    model_advance();
  endtask

  task automatic wait_init();
    int k;
    k = 0;
    while (!init_done && k < 60) begin
      cycle(1'b0, 8'h00);
      k++;
    end
    if (!init_done) fail_now("init_timeout");
  endtask

  task automatic push_byte(input logic [7:0] d);
    int k;
    k = 0;
    accepted = 0;
    while (!accepted && k < 200) begin
      cycle(1'b1, d);
      k++;
    end
    if (!accepted) fail_now("push_timeout");
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((q.size() != 0 || PSEL) && k < bound) begin
      cycle(1'b0, 8'h00);
      k++;
    end
    if (k >= bound) fail_now("drain_timeout");
    cycle(1'b0, 8'h00);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [39:0] got;
    int k;
    fixed_wait = 0; force_busy = 0; rand_busy = 0;
    last_reads = 0; last_pen_len = 0;

    // Reset values, then the init write sequence cycle by cycle.
    do_reset(3);
    for (int c = 1; c <= 6; c++) begin
      cycle(1'b0, 8'h00);
      case (c)
        1: begin
          chk("init_c1", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 10'd4, 32'd16});
          chk("tx_ready_c1", tx_ready, 1);
        end
        2: chk("init_c2", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 10'd4, 32'd16});
        3: chk("init_c3", PSEL, 0);
        4: chk("init_c4", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 10'd2, 32'h1});
        5: begin
          chk("init_c5", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 10'd2, 32'h1});
          chk("init_done_c5", init_done, 0);
        end
        default: chk("init_done_c6", {init_done, PSEL}, 2'b10);
      endcase
    end

    // Single byte, UART ready at once.
    wlog.delete();
    push_byte(8'h55);
    drain(200);
    chk("s32_count", wlog.size(), 1);
    chk("s32_byte", wlog[0], 8'h55);
    chk("s32_reads", last_reads, 1);
    chk("s32_busy", busy, 0);

    // Three STATE reads report buffer full.
    force_busy = 3;
    wlog.delete();
    push_byte(8'hA3);
    drain(300);
    chk("s33_reads", last_reads, 4);
    chk("s33_byte", wlog[0], 8'hA3);

    // Slave wait states.
    fixed_wait = 3;
    push_byte(8'h3C);
    drain(300);
    chk("s35_access_len", last_pen_len, 4);
    fixed_wait = 0;

    // Back-to-back pushes during init.
    do_reset(2);
    wlog.delete();
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i));
      if (i == DEPTH) begin
        cycle(1'b0, 8'h00);
        chk("s34_full", tx_ready, 0);
      end
    end
    drain(500);
    chk("s34_count", wlog.size(), 5);
    got = '0;
    for (int i = 0; i < 5; i++) got = {got[31:0], wlog[i]};
    chk("s34_order", got, 40'h0102030405);

    // Reset while a DATA write is stalled in ACCESS.
    fixed_wait = 4;
    push_byte(8'hE7);
    k = 0;
    while (!(PSEL && PENABLE && PWRITE && PADDR == 10'd0) && k < 60) begin
      cycle(1'b0, 8'h00);
      k++;
    end
    if (k >= 60) fail_now("s36_send_timeout");
    #2 PRESETn = 1'b0;
    #1 chk("s36_abort", {PSEL, PENABLE, fifo_count, tx_ready}, '0);
    model_reset();
    fixed_wait = 0;
    repeat (2) cycle(1'b0, 8'h00);
    PRESETn = 1'b1;
    model_advance();
    cycle(1'b0, 8'h00);
    chk("s36_rebaud", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 10'd4, 32'd16});
    wait_init();

    // Randomized traffic, wait states and busy responses.
    rand_busy = 1;
    fixed_wait = -1;
    repeat (800) cycle(($urandom_range(0, 2) != 0), 8'($urandom()));
    drain(4000);
    chk("rand_end_busy", busy, 0);
    chk("rand_end_count", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_apb_tx_ctrl.md
UART_APB_TX_CTRL -- requirements
Module: uart_apb_tx_ctrl

Interface
REQ-001 The block SHALL have parameter BAUDDIV_VAL, default 32'd16, the value written to the UART BAUDDIV register at init.
REQ-002 The block SHALL have parameter FIFO_DEPTH_LOG2, default 2, which sets the byte FIFO depth to 4 entries.
REQ-003 The block SHALL have port PCLK, input, 1 bit, the single clock.
REQ-004 The block SHALL have port PRESETn, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have ports tx_data (input, 8 bits), tx_valid (input, 1 bit) and tx_ready (output, 1 bit), forming the byte push handshake.
REQ-006 The block SHALL have APB master outputs PSEL (1), PADDR[11:2] (10), PENABLE (1), PWRITE (1) and PWDATA (32) to the cmsdk_apb_uart.
REQ-007 The block SHALL have APB master inputs PRDATA (32) and PREADY (1) from the cmsdk_apb_uart.
REQ-008 The block SHALL have outputs init_done (1 bit, UART configured), busy (1 bit, FIFO non-empty or a transfer in flight) and fifo_count (FIFO_DEPTH_LOG2+1 bits).

Function
REQ-009 UART word addresses SHALL be: DATA=10'd0, STATE=10'd1, CTRL=10'd2, BAUDDIV=10'd4.
REQ-010 Every APB transfer SHALL be one SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1), held until PREADY=1 is sampled.
REQ-011 PADDR, PWRITE and PWDATA SHALL be stable from SETUP until the completing ACCESS cycle.
REQ-012 PSEL SHALL be 0 between transfers, giving a minimum of one idle cycle after each completed transfer.
REQ-013 The FSM SHALL have states INIT_BAUD -> INIT_CTRL -> IDLE -> POLL -> SEND -> IDLE.
REQ-014 In INIT_BAUD the block SHALL write BAUDDIV_VAL to BAUDDIV.
REQ-015 In INIT_CTRL the block SHALL write 32'h1 to CTRL (TX enable); init_done SHALL rise the cycle after this write completes.
REQ-016 In IDLE with the FIFO non-empty, the block SHALL enter POLL and read STATE.
REQ-017 In POLL, if PRDATA[0]=1 (TX buffer full), the block SHALL return to idle for one cycle and re-read STATE; if PRDATA[0]=0, it SHALL go to SEND.
REQ-018 In SEND the block SHALL write {24'h0, head byte} to DATA and pop the FIFO in the completing ACCESS cycle.
REQ-019 tx_ready SHALL equal (FIFO not full); a push occurs when tx_valid && tx_ready at a rising edge.
REQ-020 Pushes SHALL be accepted in any state, including during init.
REQ-021 A simultaneous push and pop SHALL leave fifo_count unchanged, with the pushed byte enqueued behind the remaining entries.
REQ-022 FIFO pointers SHALL wrap modulo depth; a push when full SHALL be impossible because tx_ready=0.
REQ-023 Bytes SHALL be written to DATA in push order, with no loss or duplication.

Reset
REQ-024 On PRESETn=0, the FSM SHALL go to INIT_BAUD and the FIFO SHALL empty.
REQ-025 While PRESETn=0, outputs SHALL be: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, init_done=0, busy=0, fifo_count=0, tx_ready=0.
REQ-026 The first SETUP cycle (the BAUDDIV write) SHALL occur in the first cycle after reset release.
REQ-027 tx_ready SHALL follow REQ-019 from that first cycle after reset release.
REQ-028 Reset mid-transfer SHALL abort immediately: PSEL and PENABLE SHALL drop asynchronously, any in-flight byte SHALL be discarded, and the full init sequence SHALL be re-run.

Configuration
REQ-029 With UART_TX_CTRL_FIFO_EN defined, the FIFO SHALL hold 2**FIFO_DEPTH_LOG2 entries.
REQ-030 With UART_TX_CTRL_FIFO_EN undefined, the FIFO SHALL be a single-entry holding register: tx_ready=0 while it is occupied, fifo_count is 0 or 1, and FIFO_DEPTH_LOG2 is ignored.

Verification
REQ-031 Scenario: PREADY tied 1, reset release -> BAUDDIV write of 32'd16 at PADDR=4 in cycles 1-2, CTRL write of 32'h1 at PADDR=2 in cycles 4-5, init_done=1 in cycle 6.
REQ-032 Scenario: after init, push 8'h55 with PRDATA=0 -> STATE read at PADDR=1, then DATA write with PWDATA=32'h55; busy returns to 0.
REQ-033 Scenario: PRDATA[0]=1 for 3 STATE reads, then 0 -> exactly 4 STATE reads, then one DATA write.
REQ-034 Scenario: push 0x01..0x05 back-to-back during init (FIFO_EN defined) -> tx_ready=0 after the 4th push; DATA writes occur in order 01, 02, 03, 04, 05.
REQ-035 Scenario: PREADY held 0 for 3 ACCESS cycles -> PADDR/PWDATA stable throughout, with PENABLE=1 for 4 cycles.
REQ-036 Scenario: PRESETn asserted during SEND ACCESS -> PSEL=0 immediately, fifo_count=0, and BAUDDIV is rewritten after release.
